dvi_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 DVI generator. It produces the pixel raster, sync and data-enable signals for any timing set through parameters, and drives three tmds_channel encoders. It adds a configurable pixel-fetch latency pipeline, start/stop control that stops only at a frame boundary, and a frame counter. It sits between the pixel source (framebuffer/renderer) and the TMDS serialisers.

---
 rtl/dvi_timing_gen.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_dvi_timing_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : dvi_timing_gen (+ tmds_channel encoder)
// Purpose  : parametrised DVI raster/sync/DE generator feeding three TMDS
//            encoders; optional colour-bar source under macro TEST_PATTERN_EN
// Revision : 1.0
// ============================================================================

module tmds_channel (
   input  logic       clk_pixel,
   input  logic       n_reset,
   input  logic [7:0] video_data,
   input  logic [3:0] data_island_data,
   input  logic [1:0] control_data,
   input  logic [1:0] mode,
   output logic [9:0] tmds
);
   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [1:0] MODE_VIDEO  = 2'd1;
   localparam logic [1:0] MODE_ISLAND = 2'd2;

   logic [3:0]        n1_d, n1_q, n0_q;
   logic              use_xnor;
   logic [8:0]        q_m;
   logic signed [5:0] cnt, cnt_next, bal;
   logic [9:0]        word, ctrl_word, terc4_word;

   // Transition minimisation followed by running-disparity balancing.
   always_comb begin
      n1_d = '0;
      for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, video_data[i]};
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !video_data[0]);
      q_m    = '0;
      q_m[0] = video_data[0];
      for (int i = 1; i < 8; i++)
         q_m[i] = use_xnor ? ~(q_m[i-1] ^ video_data[i]) : (q_m[i-1] ^ video_data[i]);
      q_m[8] = ~use_xnor;
      n1_q = '0;
      for (int i = 0; i < 8; i++) n1_q = n1_q + {3'b000, q_m[i]};
      n0_q = 4'd8 - n1_q;
      bal  = $signed({2'b00, n1_q}) - $signed({2'b00, n0_q});
      if ((cnt == 6'sd0) || (n1_q == n0_q)) begin
         word     = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
         cnt_next = q_m[8] ? (cnt + bal) : (cnt - bal);
      end else if (((cnt > 6'sd0) && (n1_q > n0_q)) || ((cnt < 6'sd0) && (n0_q > n1_q))) begin
         word     = {1'b1, q_m[8], ~q_m[7:0]};
         cnt_next = cnt + (q_m[8] ? 6'sd2 : 6'sd0) - bal;
      end else begin
         word     = {1'b0, q_m[8], q_m[7:0]};
         cnt_next = cnt - (q_m[8] ? 6'sd0 : 6'sd2) + bal;
      end
   end

   always_comb begin
      ctrl_word = CTRL_00;
      case (control_data)
         2'b00:   ctrl_word = 10'b1101010100;
         2'b01:   ctrl_word = 10'b0010101011;
         2'b10:   ctrl_word = 10'b0101010100;
         default: ctrl_word = 10'b1010101011;
      endcase
   end

   always_comb begin
      terc4_word = 10'b1010011100;
      case (data_island_data)
         4'h0: terc4_word = 10'b1010011100;
         4'h1: terc4_word = 10'b1001100011;
         4'h2: terc4_word = 10'b1011100100;
         4'h3: terc4_word = 10'b1011100010;
         4'h4: terc4_word = 10'b0101110001;
         4'h5: terc4_word = 10'b0100011110;
         4'h6: terc4_word = 10'b0110001110;
         4'h7: terc4_word = 10'b0100111100;
         4'h8: terc4_word = 10'b1011001100;
         4'h9: terc4_word = 10'b0100111001;
         4'hA: terc4_word = 10'b0110011100;
         4'hB: terc4_word = 10'b1011000110;
         4'hC: terc4_word = 10'b1010001110;
         4'hD: terc4_word = 10'b1001110001;
         4'hE: terc4_word = 10'b0101100011;
         default: terc4_word = 10'b1011000011;
      endcase
   end

   // Disparity restarts from zero after every non-video period.
   always_ff @(posedge clk_pixel or negedge n_reset) begin
      if (!n_reset) begin
         tmds <= CTRL_00;
         cnt  <= '0;
      end else begin
         case (mode)
            MODE_VIDEO: begin
               tmds <= word;
               cnt  <= cnt_next;
            end
            MODE_ISLAND: begin
               tmds <= terc4_word;
               cnt  <= '0;
            end
            default: begin
               tmds <= ctrl_word;
               cnt  <= '0;
            end
         endcase
      end
   end
endmodule

module dvi_timing_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int H_SYNC_POL  = 0,
   parameter int V_SYNC_POL  = 0,
   parameter int PIX_LATENCY = 1,
   parameter int CW          = 12
) (
   input  logic          clk_pixel,
   input  logic          n_reset,
   input  logic          enable,
   input  logic [23:0]   rgb_data,
`ifdef TEST_PATTERN_EN
   input  logic          pattern_en,
`endif
   output logic [9:0]    tmds_r,
   output logic [9:0]    tmds_g,
   output logic [9:0]    tmds_b,
   output logic [CW-1:0] xpos,
   output logic [CW-1:0] ypos,
   output logic          active,
   output logic          line_end,
   output logic          frame_end,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic          running,
   output logic [15:0]   frame_count
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_ACTIVE < 1 ||
          V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CW < 1) begin : g_bad_width
         $error("dvi_timing_gen: every timing width and CW must be at least 1");
      end
      if (PIX_LATENCY < 1 || PIX_LATENCY > 8) begin : g_bad_latency
         $error("dvi_timing_gen: PIX_LATENCY must be in 1..8");
      end
      if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
         $error("dvi_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
      end
   endgenerate

   // Constants carry one spare bit so sync end points equal to a total still fit.
   localparam logic [CW:0] X_LAST   = (CW+1)'(H_TOTAL - 1);
   localparam logic [CW:0] Y_LAST   = (CW+1)'(V_TOTAL - 1);
   localparam logic [CW:0] X_ACT    = (CW+1)'(H_ACTIVE);
   localparam logic [CW:0] Y_ACT    = (CW+1)'(V_ACTIVE);
   localparam logic [CW:0] X_ACT_M1 = (CW+1)'(H_ACTIVE - 1);
   localparam logic [CW:0] Y_ACT_M1 = (CW+1)'(V_ACTIVE - 1);
   localparam logic [CW:0] HS_START = (CW+1)'(H_ACTIVE + H_FP);
   localparam logic [CW:0] HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW:0] VS_PRE   = (CW+1)'(V_ACTIVE + V_FP - 1);
   localparam logic [CW:0] VS_START = (CW+1)'(V_ACTIVE + V_FP);
   localparam logic [CW:0] VS_LAST  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic        HS_INACT = (H_SYNC_POL == 0);
   localparam logic        VS_INACT = (V_SYNC_POL == 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [CW:0] xe, ye;
   logic        x_last, y_last, frame_last;
   logic        hs_raw, vs_raw, hs_after;
   logic [2:0]  pipe [PIX_LATENCY];
   logic [23:0] pix, vid_q;
   logic [1:0]  mode_q, ctrl_b_q;

   assign xe         = {1'b0, xpos};
   assign ye         = {1'b0, ypos};
   assign x_last     = (xe == X_LAST);
   assign y_last     = (ye == Y_LAST);
   assign frame_last = x_last && y_last;
   assign running    = (state != IDLE);

   always_ff @(posedge clk_pixel or negedge n_reset) begin
      if (!n_reset) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable) state_next = RUN;
         RUN:     if (!enable) state_next = DRAIN;
         DRAIN: begin
            if (enable)          state_next = RUN;
            else if (frame_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The counters sit at (0,0) in IDLE because the stopping wrap leaves them there.
   always_ff @(posedge clk_pixel or negedge n_reset) begin
      if (!n_reset) begin
         xpos        <= '0;
         ypos        <= '0;
         frame_count <= '0;
      end else if (running) begin
         xpos <= x_last ? '0 : xpos + CW'(1);
         if (x_last) ypos <= y_last ? '0 : ypos + CW'(1);
         if (frame_last) frame_count <= frame_count + 16'd1;
      end
   end

   assign active    = running && (xe < X_ACT) && (ye < Y_ACT);
   assign line_end  = running && (xe == X_ACT_M1) && (ye < Y_ACT);
   assign frame_end = running && (xe == X_ACT_M1) && (ye == Y_ACT_M1);
   assign hs_after  = (xe >= HS_START);
   assign hs_raw    = running && hs_after && (xe < HS_END);
   // Vertical sync edges coincide with the hsync leading edge.
   assign vs_raw    = running && (((ye == VS_PRE) && hs_after) ||
                                  ((ye >= VS_START) && (ye < VS_LAST)) ||
                                  ((ye == VS_LAST) && !hs_after));

   always_ff @(posedge clk_pixel or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < PIX_LATENCY; i++) pipe[i] <= 3'b000;
      end else begin
         pipe[0] <= {active, hs_raw, vs_raw};
         for (int i = 1; i < PIX_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign de    = pipe[PIX_LATENCY-1][2];
   assign hsync = pipe[PIX_LATENCY-1][1] ^ HS_INACT;
   assign vsync = pipe[PIX_LATENCY-1][0] ^ VS_INACT;

`ifdef TEST_PATTERN_EN
   logic [CW-1:0] xpipe [PIX_LATENCY];
   logic [2:0]    bar_idx;
   logic [23:0]   bar_rgb;

   always_ff @(posedge clk_pixel or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < PIX_LATENCY; i++) xpipe[i] <= '0;
      end else begin
         xpipe[0] <= xpos;
         for (int i = 1; i < PIX_LATENCY; i++) xpipe[i] <= xpipe[i-1];
      end
   end

   always_comb begin
      bar_idx = 3'd0;
      for (int k = 1; k < 8; k++)
         if ({1'b0, xpipe[PIX_LATENCY-1]} >= (CW+1)'((k * H_ACTIVE) / 8)) bar_idx = bar_idx + 3'd1;
      case (bar_idx)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end

   assign pix = pattern_en ? bar_rgb : rgb_data;
`else
   assign pix = rgb_data;
`endif

   always_ff @(posedge clk_pixel or negedge n_reset) begin
      if (!n_reset) begin
         vid_q    <= '0;
         mode_q   <= 2'd0;
         ctrl_b_q <= {VS_INACT, HS_INACT};
      end else begin
         vid_q    <= de ? pix : 24'h000000;
         mode_q   <= de ? 2'd1 : 2'd0;
         ctrl_b_q <= {vsync, hsync};
      end
   end

   tmds_channel u_tmds_r (
      .clk_pixel        (clk_pixel),
      .n_reset          (n_reset),
      .video_data       (vid_q[23:16]),
      .data_island_data (4'h0),
      .control_data     (2'b00),
      .mode             (mode_q),
      .tmds             (tmds_r)
   );

   tmds_channel u_tmds_g (
      .clk_pixel        (clk_pixel),
      .n_reset          (n_reset),
      .video_data       (vid_q[15:8]),
      .data_island_data (4'h0),
      .control_data     (2'b00),
      .mode             (mode_q),
      .tmds             (tmds_g)
   );

   tmds_channel u_tmds_b (
      .clk_pixel        (clk_pixel),
      .n_reset          (n_reset),
      .video_data       (vid_q[7:0]),
      .data_island_data (4'h0),
      .control_data     (ctrl_b_q),
      .mode             (mode_q),
      .tmds             (tmds_b)
   );
endmodule

`default_nettype wire

// File: tb/tb_dvi_timing_gen.sv
`default_nettype none
// Bench for dvi_timing_gen: small 16x8 raster, positional reference model, TMDS decode.
module tb_dvi_timing_gen;
   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int L = 2, CW = 12;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int NPIX = HT * VT;
   localparam int VS0 = (VA + VF - 1) * HT + HA + HF;
   localparam int VS1 = (VA + VF + VS - 1) * HT + HA + HF;
   localparam int D = L + 3;

   logic          clk = 1'b0;
   logic          n_reset = 1'b0;
   logic          enable = 1'b0;
   logic [23:0]   rgb_data = '0;
`ifdef TEST_PATTERN_EN
   logic          pattern_en = 1'b0;
`endif
   logic [9:0]    tmds_r, tmds_g, tmds_b;
   logic [CW-1:0] xpos, ypos;
   logic          active, line_end, frame_end, de, hsync, vsync, running;
   logic [15:0]   frame_count;

   dvi_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(1), .V_SYNC_POL(1), .PIX_LATENCY(L), .CW(CW)
   ) dut (
      .clk_pixel(clk), .n_reset(n_reset), .enable(enable), .rgb_data(rgb_data),
`ifdef TEST_PATTERN_EN
      .pattern_en(pattern_en),
`endif
      .tmds_r(tmds_r), .tmds_g(tmds_g), .tmds_b(tmds_b),
      .xpos(xpos), .ypos(ypos), .active(active), .line_end(line_end),
      .frame_end(frame_end), .de(de), .hsync(hsync), .vsync(vsync),
      .running(running), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // Model: the generator is either stopped, or at raster position m_pos;
   // it stops after the last pixel once enable has been low on two running edges.
   bit          m_run, m_prev_low, m_e, m_last, m_stop, pat_mode;
   int          m_pos, m_frames;
   bit          h_a [D];
   bit          h_h [D];
   bit          h_v [D];
   logic [23:0] h_rgb [D];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void raw_at(input int pos, input bit run, output bit a, output bit h, output bit v);
      int x, y;
      x = pos % HT;
      y = pos / HT;
      a = run && (x < HA) && (y < VA);
      h = run && (x >= HA + HF) && (x < HA + HF + HS);
      v = run && (pos >= VS0) && (pos < VS1);
   endfunction

   function automatic logic [7:0] tmds_dec(input logic [9:0] q);
      logic [7:0] d, o;
      d = q[9] ? ~q[7:0] : q[7:0];
      o[0] = d[0];
      for (int i = 1; i < 8; i++) o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      return o;
   endfunction

   function automatic logic [9:0] tok(input logic [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   task automatic model_reset();
      m_run = 0; m_prev_low = 0; m_pos = 0; m_frames = 0;
      for (int i = 0; i < D; i++) begin
         h_a[i] = 0; h_h[i] = 0; h_v[i] = 0; h_rgb[i] = '0;
      end
   endtask

   always @(negedge n_reset) model_reset();

   always @(posedge clk) begin
      if (!n_reset) begin
         model_reset();
      end else begin
         m_e = enable;
         for (int i = D - 1; i > 0; i--) begin
            h_a[i] = h_a[i-1]; h_h[i] = h_h[i-1]; h_v[i] = h_v[i-1]; h_rgb[i] = h_rgb[i-1];
         end
         if (!m_run) begin
            if (m_e) begin
               m_run = 1; m_pos = 0; m_prev_low = 0;
            end
         end else begin
            m_last = (m_pos == NPIX - 1);
            m_stop = m_last && !m_e && m_prev_low;
            m_pos = (m_pos + 1) % NPIX;
            if (m_last) m_frames = (m_frames + 1) % 65536;
            m_prev_low = !m_e;
            if (m_stop) begin
               m_run = 0; m_prev_low = 0;
            end
         end
         raw_at(m_pos, m_run, h_a[0], h_h[0], h_v[0]);
         h_rgb[0] = pat_mode ? {8'(m_pos / HT), 8'(m_pos % HT), 8'hA5} : 24'($urandom);
         #1 rgb_data = h_rgb[L];
      end
   end

   always @(negedge clk) begin
      int x, y;
      x = m_pos % HT;
      y = m_pos / HT;
      check("running", running, m_run);
      check("xpos", xpos, x);
      check("ypos", ypos, y);
      check("active", active, m_run && x < HA && y < VA);
      check("line_end", line_end, m_run && x == HA - 1 && y < VA);
      check("frame_end", frame_end, m_run && x == HA - 1 && y == VA - 1);
      check("frame_count", frame_count, m_frames);
      check("de", de, h_a[L]);
      check("hsync", hsync, h_h[L]);
      check("vsync", vsync, h_v[L]);
      if (h_a[L+2]) begin
         check("tmds_b_data", tmds_dec(tmds_b), h_rgb[L+2][7:0]);
         check("tmds_g_data", tmds_dec(tmds_g), h_rgb[L+2][15:8]);
         check("tmds_r_data", tmds_dec(tmds_r), h_rgb[L+2][23:16]);
      end else begin
         check("tmds_b_ctrl", tmds_b, tok({h_v[L+2], h_h[L+2]}));
         check("tmds_g_ctrl", tmds_g, tok(2'b00));
         check("tmds_r_ctrl", tmds_r, tok(2'b00));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_xy(input int x, input int y);
      int k;
      k = 0;
      while (!(running && xpos == x && ypos == y) && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (k >= 400) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_xy: position (%0d,%0d) not reached, got (%0d,%0d)", x, y, xpos, ypos);
      end
   endtask

   task automatic wait_stop(input string name, input int exp_cycles);
      int k;
      k = 0;
      while (running && k < 400) begin
         @(negedge clk);
         k++;
      end
      check(name, k, exp_cycles);
   endtask

   initial begin
      int fc0;
      model_reset();
      pat_mode = 1;
      cycles(3);
      n_reset = 1;
      cycles(50);
      check("idle_xpos", xpos, 0);
      check("idle_ypos", ypos, 0);
      check("idle_running", running, 0);
      check("idle_de", de, 0);
      check("idle_hsync", hsync, 0);
      check("idle_vsync", vsync, 0);
      check("idle_frames", frame_count, 0);

      enable = 1;
      wait_xy(10, 0);
      cycles(1); check("hs_x10_p1", hsync, 0);
      cycles(1); check("hs_x10_p2", hsync, 1);
      cycles(2); check("hs_x12_p2", hsync, 1);
      cycles(1); check("hs_x12_p3", hsync, 0);
      wait_xy(5, 1);
      cycles(L + 2);
      check("lit_blue_a5", tmds_dec(tmds_b), 8'hA5);
      check("lit_green_x", tmds_dec(tmds_g), 8'd5);
      check("lit_red_y", tmds_dec(tmds_r), 8'd1);
      wait_xy(10, 4);
      cycles(1); check("vs_rise_p1", vsync, 0);
      cycles(1); check("vs_rise_p2", vsync, 1); check("hs_with_vs", hsync, 1);
      wait_xy(10, 6);
      cycles(1); check("vs_fall_p1", vsync, 1);
      cycles(1); check("vs_fall_p2", vsync, 0);
      wait_xy(15, 7);
      check("frames_before_wrap", frame_count, 0);
      cycles(1);
      check("frames_after_128", frame_count, 1);
      check("wrap_xpos", xpos, 0);

      pat_mode = 0;
      wait_xy(3, 2);
      enable = 0;
      fc0 = int'(frame_count);
      wait_stop("drain_len", 93);
      check("stop_xpos", xpos, 0);
      check("stop_ypos", ypos, 0);
      check("stop_frames", frame_count, fc0 + 1);
      cycles(10);
      check("stays_idle", running, 0);

      enable = 1;
      wait_xy(7, 3);
      enable = 0;
      cycles(20 + $urandom_range(0, 40));
      enable = 1;
      cycles(100);
      check("reenable_running", running, 1);

      wait_xy(15, 7);
      enable = 0;
      wait_stop("last_pixel_drain", 129);

      repeat (20) begin
         pat_mode = $urandom_range(0, 1);
         enable = $urandom_range(0, 1);
         cycles($urandom_range(1, 150));
      end

      enable = 1;
      wait_xy(5, 3);
      #2 n_reset = 0;
      #1;
      check("rst_xpos", xpos, 0);
      check("rst_ypos", ypos, 0);
      check("rst_running", running, 0);
      check("rst_de", de, 0);
      check("rst_hsync", hsync, 0);
      check("rst_vsync", vsync, 0);
      check("rst_frames", frame_count, 0);
      check("rst_active", active, 0);
      @(negedge clk);
      #2 n_reset = 1;
      @(negedge clk);
      check("restart_running", running, 1);
      check("restart_xpos", xpos, 0);
      @(negedge clk);
      check("restart_xpos1", xpos, 1);
      cycles(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
